// File: rtl/pci_pkg.sv
// pci_pkg: shared definitions for the PCI master controller.
//   pci_state_t   - master sequencer states
//   MEM_READ/MEM_WRITE - memory command codes (cmd[0] selects write)
//   DEVSEL_TIMEOUT_DEF / MAX_PHASES_DEF - default parameter values
//   clampCount    - maps a requested phase count onto 1..maxPhases
package pci_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    ADDR = 3'd2,
    DATA = 3'd3,
    TURN = 3'd4
  } pci_state_t;

  localparam logic [3:0] MEM_READ  = 4'b0110;
  localparam logic [3:0] MEM_WRITE = 4'b0111;

  localparam int DEVSEL_TIMEOUT_DEF = 5;
  localparam int MAX_PHASES_DEF     = 7;

  // Zero phases makes no sense on the bus, so it runs as a single phase;
  // anything above the configured maximum is clipped to that maximum.
  function automatic logic [2:0] clampCount(input logic [2:0] dc, input int maxPhases);
    logic [2:0] r;
    if (dc == 3'd0) begin
      r = 3'd1;
    end else if (int'(dc) > maxPhases) begin
      r = 3'(maxPhases);
    end else begin
      r = dc;
    end
    return r;
  endfunction

endpackage

// File: rtl/pci_master_ctrl_if.sv
// pci_master_ctrl_if: PCI bus signals between the master controller and a target.
//   master modport: drives req/frame/irdy/cbe/ad_out/ad_oe, samples gnt/devSelect/trdy/ad_in
//   slave modport : the mirror image, used by a target model
// All control lines are active-low. Handshake: a data phase transfers on
// exactly those clocks where irdy=0, trdy=0 and devSelect=0 together; the
// master holds irdy low for the whole data window, the target inserts wait
// states by holding trdy high, and trdy low without devSelect low is ignored.
interface pci_master_ctrl_if;
  import pci_pkg::*;

  logic        gnt;
  logic        devSelect;
  logic        trdy;
  logic [31:0] ad_in;
  logic        req;
  logic        frame;
  logic        irdy;
  logic [3:0]  cbe;
  logic [31:0] ad_out;
  logic        ad_oe;

  modport master (
    input  gnt, devSelect, trdy, ad_in,
    output req, frame, irdy, cbe, ad_out, ad_oe
  );

  modport slave (
    output gnt, devSelect, trdy, ad_in,
    input  req, frame, irdy, cbe, ad_out, ad_oe
  );

endinterface

// File: rtl/pci_devsel_timer.sv
// pci_devsel_timer: counts data-phase clocks with devSelect high.
//   clk, rst  - clock, synchronous active-high reset
//   start     - clears the timer (asserted during the address phase)
//   devSelect - active-low target claim
//   enable    - high while the master is in its data window
//   expired   - high once TIMEOUT unclaimed clocks have elapsed
// A single low devSelect freezes the timer for the rest of the transaction.
module pci_devsel_timer
  import pci_pkg::*;
#(
  parameter int TIMEOUT = DEVSEL_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic devSelect,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;
  logic          stopped;

  always_ff @(posedge clk) begin
    if (rst || start) begin
      count   <= '0;
      stopped <= 1'b0;
    end else if (enable && !stopped && !expired) begin
      if (!devSelect) begin
        stopped <= 1'b1;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

  assign expired = !stopped && (count == CW'(TIMEOUT));

endmodule

// File: rtl/pci_master_ctrl.sv
// pci_master_ctrl: single-initiator PCI master sequencer.
//   clk, rst      - clock, synchronous active-high reset
//   req_start     - one-cycle request pulse (ignored while busy)
//   cmd/addr/data_count - transaction descriptor, captured with req_start
//   wr_data       - write word for the current data phase
//   bus           - PCI bus (master modport)
//   rd_data/rd_valid - read word, valid on the completing clock
//   wr_data_req   - current write word consumed on this clock
//   busy/done/master_abort - status; done and master_abort are pulses
//   dbgState      - current sequencer state
module pci_master_ctrl
  import pci_pkg::*;
#(
  parameter int DEVSEL_TIMEOUT = DEVSEL_TIMEOUT_DEF,
  parameter int MAX_PHASES     = MAX_PHASES_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_start,
  input  logic [3:0]               cmd,
  input  logic [31:0]              addr,
  input  logic [2:0]               data_count,
  input  logic [31:0]              wr_data,
  pci_master_ctrl_if.master        bus,
  output logic [31:0]              rd_data,
  output logic                     rd_valid,
  output logic                     wr_data_req,
  output logic                     busy,
  output logic                     done,
  output logic                     master_abort,
  output pci_state_t               dbgState
);

  pci_state_t  state;
  pci_state_t  nextState;
  logic [3:0]  cmdQ;
  logic [31:0] addrQ;
  logic [2:0]  remaining;

  logic expired;
  logic abort;
  logic phaseDone;
  logic lastPhase;
  logic isWrite;

  pci_devsel_timer #(.TIMEOUT(DEVSEL_TIMEOUT)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .start    (state == ADDR),
    .devSelect(bus.devSelect),
    .enable   (state == DATA),
    .expired  (expired)
  );

  assign isWrite   = cmdQ[0];
  assign lastPhase = (remaining == 3'd1);
  assign abort     = (state == DATA) && expired;
  // irdy is low for every DATA clock, so only the target side gates a phase.
  assign phaseDone = (state == DATA) && !abort && !bus.devSelect && !bus.trdy;

  assign busy     = (state != IDLE);
  assign dbgState = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cmdQ      <= '0;
      addrQ     <= '0;
      remaining <= '0;
    end else begin
      state <= nextState;
      if (state == IDLE && req_start) begin
        cmdQ      <= cmd;
        addrQ     <= addr;
        remaining <= clampCount(data_count, MAX_PHASES);
      end else if (phaseDone) begin
        remaining <= remaining - 3'd1;
      end
    end
  end

  always_comb begin
    nextState    = state;
    bus.req      = 1'b1;
    bus.frame    = 1'b1;
    bus.irdy     = 1'b1;
    bus.cbe      = 4'b0000;
    bus.ad_out   = '0;
    bus.ad_oe    = 1'b0;
    rd_data      = '0;
    rd_valid     = 1'b0;
    wr_data_req  = 1'b0;
    done         = 1'b0;
    master_abort = 1'b0;

    case (state)
      IDLE: begin
        if (req_start) nextState = REQ;
      end
      REQ: begin
        bus.req = 1'b0;
        if (!bus.gnt) nextState = ADDR;
      end
      ADDR: begin
        bus.frame  = 1'b0;
        bus.ad_oe  = 1'b1;
        bus.ad_out = addrQ;
        bus.cbe    = cmdQ;
        nextState  = DATA;
      end
      DATA: begin
        bus.irdy  = 1'b0;
        bus.ad_oe = isWrite;
        if (isWrite) bus.ad_out = wr_data;
        // frame released on the final phase, or for the single abort clock
        bus.frame = lastPhase || abort;
        if (abort) begin
          master_abort = 1'b1;
          nextState    = TURN;
        end else if (phaseDone) begin
          if (isWrite) begin
            wr_data_req = 1'b1;
          end else begin
            rd_valid = 1'b1;
            rd_data  = bus.ad_in;
          end
          if (lastPhase) nextState = TURN;
        end
      end
      TURN: begin
        done      = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pci_master_ctrl.sv
module tb_pci_master_ctrl;
  import pci_pkg::*;

  localparam int TO   = 5;
  localparam int MAXP = 6;
  localparam logic [76:0] RST_VEC = {3'b111, 74'd0};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_start = 1'b0;
  logic [3:0]  cmd = '0;
  logic [31:0] addr = '0;
  logic [2:0]  data_count = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data;
  logic        rd_valid, wr_data_req, busy, done, master_abort;
  pci_state_t  dbgState;

  pci_master_ctrl_if bus();

  pci_master_ctrl #(.DEVSEL_TIMEOUT(TO), .MAX_PHASES(MAXP)) dut (
    .clk(clk), .rst(rst), .req_start(req_start), .cmd(cmd), .addr(addr),
    .data_count(data_count), .wr_data(wr_data), .bus(bus), .rd_data(rd_data),
    .rd_valid(rd_valid), .wr_data_req(wr_data_req), .busy(busy), .done(done),
    .master_abort(master_abort), .dbgState(dbgState)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // target scenario
  int          phaseWait[8];
  logic [31:0] rdWords[8];
  logic [31:0] wrWords[8];

  // scoreboard and per-transaction observations
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  int          frameHighPh[$];
  int addrCyc, dataStart, abortCyc, abortCnt, doneCyc, doneCnt;
  int irdyGap, reqBad, busyBad, turnBad, idleBad, nRd, nWr;
  logic [31:0] addrAd;
  logic [3:0]  addrCbe;
  logic        addrOe;
  bit          timedOut;

  function automatic logic [76:0] outVec();
    return {bus.req, bus.frame, bus.irdy, bus.cbe, bus.ad_out, bus.ad_oe,
            rd_data, rd_valid, wr_data_req, busy, done, master_abort};
  endfunction

  task automatic fill_words();
    for (int i = 0; i < 8; i++) begin
      rdWords[i] = $urandom;
      wrWords[i] = $urandom;
      phaseWait[i] = 0;
    end
  endtask

  // Plays one transaction as arbiter + target, recording what the master did.
  task automatic drive_txn(input logic [3:0] c, input logic [31:0] a, input logic [2:0] cnt,
                           input int gntDelay, input int devselDelay, input int rstAtPh,
                           input bit noise);
    int k, dCyc, ph, wrIdx, waitLeft;
    bit devselOn, inD, afterDone, fin;
    obs_q.delete();
    frameHighPh.delete();
    addrCyc = -1; dataStart = -1; abortCyc = -1; abortCnt = 0; doneCyc = -1; doneCnt = 0;
    irdyGap = 0; reqBad = 0; busyBad = 0; turnBad = 0; idleBad = 0; nRd = 0; nWr = 0;
    addrAd = '0; addrCbe = '0; addrOe = 1'b0; timedOut = 0;
    @(negedge clk);
    req_start = 1'b1; cmd = c; addr = a; data_count = cnt;
    bus.gnt = 1'b1; bus.devSelect = 1'b1; bus.trdy = 1'b1; bus.ad_in = $urandom;
    wr_data = wrWords[0];
    @(negedge clk);
    k = 0; dCyc = 0; ph = 0; wrIdx = 0; waitLeft = phaseWait[0];
    devselOn = 0; afterDone = 0; fin = 0;
    while (!fin) begin
      inD = (bus.irdy === 1'b0);
      if (afterDone) begin
        req_start = 1'b0; bus.gnt = 1'b1; bus.devSelect = 1'b1; bus.trdy = 1'b1;
        #1;
        if (busy !== 1'b0) idleBad++;
        fin = 1;
      end else begin
        req_start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        if (noise) begin
          cmd = 4'($urandom); addr = $urandom; data_count = 3'($urandom);
        end
        bus.gnt = (k < gntDelay) ? 1'b1 : 1'b0;
        bus.ad_in = $urandom;
        if (inD) begin
          if (dataStart < 0) dataStart = k;
          if (!devselOn && dCyc >= devselDelay) devselOn = 1;
          bus.devSelect = ~devselOn;
          if (devselOn) begin
            bus.trdy = (waitLeft > 0);
            if (waitLeft == 0) bus.ad_in = rdWords[ph];
          end else begin
            bus.trdy = 1'($urandom_range(0, 1));
          end
          if (ph == rstAtPh) rst = 1'b1;
        end else begin
          bus.devSelect = 1'b1;
          bus.trdy = 1'b1;
        end
        wr_data = wrWords[wrIdx];
        #1;
        if (k < gntDelay && (bus.req !== 1'b0 || bus.frame !== 1'b1 || dbgState !== REQ)) reqBad++;
        if (busy !== 1'b1) busyBad++;
        if (!inD && bus.frame === 1'b0 && addrCyc < 0) begin
          addrCyc = k; addrAd = bus.ad_out; addrCbe = bus.cbe; addrOe = bus.ad_oe;
        end
        if (inD && bus.frame === 1'b1) frameHighPh.push_back(ph);
        if (master_abort === 1'b1) begin abortCnt++; abortCyc = k; end
        if (dataStart >= 0 && !inD && done !== 1'b1) irdyGap++;
        if (rd_valid === 1'b1) begin nRd++; obs_q.push_back(rd_data); end
        if (wr_data_req === 1'b1) begin nWr++; obs_q.push_back(bus.ad_out); end
        if (done === 1'b1) begin
          doneCnt++; doneCyc = k;
          if (bus.frame !== 1'b1 || bus.irdy !== 1'b1 || bus.ad_oe !== 1'b0) turnBad++;
        end
        if (inD && devselOn) begin
          if (waitLeft > 0) waitLeft--;
          else begin
            ph++;
            waitLeft = (ph < 8) ? phaseWait[ph] : 0;
          end
        end
        if (inD) dCyc++;
        if (wr_data_req === 1'b1 && wrIdx < 7) wrIdx++;
        if (done === 1'b1) afterDone = 1;
        if (rst === 1'b1) fin = 1;
        else if (k >= 300) begin timedOut = 1; fin = 1; end
        else begin
          @(negedge clk);
          k++;
        end
      end
    end
    req_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++; if (outVec() !== RST_VEC) begin bad++; $display("FAIL reset_outputs: got %h expected %h", outVec(), RST_VEC); end
    total++; if (dbgState !== IDLE) begin bad++; $display("FAIL reset_state: got %0d expected %0d", dbgState, IDLE); end
    rst = 1'b0;
    @(negedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_single_write();
    fill_words();
    drive_txn(MEM_WRITE, 32'h0000_1000, 3'd1, 2, 0, -1, 0);
    total++; if (timedOut) begin bad++; $display("FAIL sw_timeout: got stuck expected done"); end
    total++; if (addrCyc !== 3) begin bad++; $display("FAIL sw_addr_cycle: got %0d expected 3", addrCyc); end
    total++; if (addrAd !== 32'h0000_1000 || addrCbe !== 4'b0111 || addrOe !== 1'b1)
      begin bad++; $display("FAIL sw_addr_phase: got ad=%h cbe=%b oe=%b expected ad=00001000 cbe=0111 oe=1", addrAd, addrCbe, addrOe); end
    total++; if (nWr !== 1 || nRd !== 0) begin bad++; $display("FAIL sw_req_count: got wr=%0d rd=%0d expected wr=1 rd=0", nWr, nRd); end
    total++; if (obs_q.size() != 1 || obs_q[0] !== wrWords[0])
      begin bad++; $display("FAIL sw_data: got n=%0d expected word %h", obs_q.size(), wrWords[0]); end
    total++; if (frameHighPh.size() != 1) begin bad++; $display("FAIL sw_frame_high: got %0d clocks expected 1", frameHighPh.size()); end
    total++; if (doneCyc - dataStart !== 1) begin bad++; $display("FAIL sw_done: got offset %0d expected 1", doneCyc - dataStart); end
  endtask

  task automatic test_burst_read();
    int mism;
    fill_words();
    phaseWait[1] = 2;
    drive_txn(MEM_READ, $urandom, 3'd4, 1, 0, -1, 0);
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(rdWords[i]);
    total++; if (nRd !== 4) begin bad++; $display("FAIL br_count: got %0d expected 4", nRd); end
    mism = 0;
    for (int i = 0; i < 4; i++) if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) mism++;
    total++; if (mism !== 0) begin bad++; $display("FAIL br_data_order: got %0d wrong words expected 0", mism); end
    total++; if (irdyGap !== 0) begin bad++; $display("FAIL br_irdy_held: got %0d gaps expected 0", irdyGap); end
    total++; if (frameHighPh.size() != 1 || frameHighPh[0] != 3)
      begin bad++; $display("FAIL br_frame_last: got %0d high clocks expected 1 in phase 4", frameHighPh.size()); end
    total++; if (doneCyc - dataStart !== 6) begin bad++; $display("FAIL br_done: got offset %0d expected 6", doneCyc - dataStart); end
  endtask

  task automatic test_master_abort();
    fill_words();
    drive_txn(MEM_READ, $urandom, 3'd3, 1, 100, -1, 0);
    total++; if (abortCnt !== 1) begin bad++; $display("FAIL ma_pulse_count: got %0d expected 1", abortCnt); end
    total++; if (abortCyc - dataStart !== TO) begin bad++; $display("FAIL ma_offset: got %0d expected %0d", abortCyc - dataStart, TO); end
    total++; if (nRd !== 0 || nWr !== 0) begin bad++; $display("FAIL ma_no_data: got rd=%0d wr=%0d expected 0 0", nRd, nWr); end
    total++; if (doneCyc - abortCyc !== 1 || turnBad !== 0)
      begin bad++; $display("FAIL ma_turn: got done offset %0d turnBad=%0d expected 1 0", doneCyc - abortCyc, turnBad); end
    total++; if (frameHighPh.size() != 1) begin bad++; $display("FAIL ma_frame: got %0d high clocks expected 1", frameHighPh.size()); end
    total++; if (idleBad !== 0) begin bad++; $display("FAIL ma_idle: got busy after turn expected idle"); end
  endtask

  task automatic test_gnt_wait();
    fill_words();
    drive_txn(MEM_WRITE, $urandom, 3'd2, 10, 0, -1, 0);
    total++; if (reqBad !== 0) begin bad++; $display("FAIL gw_req_hold: got %0d bad clocks expected 0", reqBad); end
    total++; if (addrCyc !== 11) begin bad++; $display("FAIL gw_addr_cycle: got %0d expected 11", addrCyc); end
    total++; if (nWr !== 2) begin bad++; $display("FAIL gw_writes: got %0d expected 2", nWr); end
  endtask

  task automatic test_reset_mid();
    int mism;
    fill_words();
    drive_txn(MEM_READ, $urandom, 3'd4, 0, 0, 1, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (outVec() !== RST_VEC) begin bad++; $display("FAIL rm_outputs: got %h expected %h", outVec(), RST_VEC); end
    total++; if (dbgState !== IDLE) begin bad++; $display("FAIL rm_state: got %0d expected %0d", dbgState, IDLE); end
    fill_words();
    drive_txn(MEM_READ, $urandom, 3'd2, 0, 0, -1, 0);
    mism = 0;
    for (int i = 0; i < 2; i++) if (i >= obs_q.size() || obs_q[i] !== rdWords[i]) mism++;
    total++; if (nRd !== 2 || mism !== 0) begin bad++; $display("FAIL rm_clean_txn: got rd=%0d wrong=%0d expected 2 0", nRd, mism); end
    total++; if (doneCyc - dataStart !== 2) begin bad++; $display("FAIL rm_done: got offset %0d expected 2", doneCyc - dataStart); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  c;
    logic [31:0] a;
    logic [2:0]  cnt;
    int g, dsd, n, sum, expDone, expFrame, mism, wrongPh;
    bit ab;
    for (int t = 0; t < 40; t++) begin
      fill_words();
      c = 4'($urandom); a = $urandom; cnt = 3'($urandom); g = $urandom_range(0, 4);
      ab = ($urandom_range(0, 3) == 0);
      dsd = ab ? 100 : $urandom_range(0, TO - 1);
      for (int i = 0; i < 8; i++) phaseWait[i] = $urandom_range(0, 3);
      drive_txn(c, a, cnt, g, dsd, -1, 1);
      // reference: phase count rule, completion times from wait totals
      n = (cnt == 0) ? 1 : ((int'(cnt) > MAXP) ? MAXP : int'(cnt));
      sum = 0;
      for (int i = 0; i < n; i++) sum += phaseWait[i];
      exp_q.delete();
      if (!ab) for (int i = 0; i < n; i++) exp_q.push_back(c[0] ? wrWords[i] : rdWords[i]);
      expDone = ab ? TO + 1 : dsd + sum + n;
      if (ab) expFrame = (n == 1) ? TO + 1 : 1;
      else expFrame = (n == 1) ? dsd + phaseWait[0] + 1 : phaseWait[n - 1] + 1;
      mism = 0;
      if (obs_q.size() != exp_q.size()) mism++;
      else for (int i = 0; i < exp_q.size(); i++) if (obs_q[i] !== exp_q[i]) mism++;
      wrongPh = 0;
      if (!ab) foreach (frameHighPh[i]) if (frameHighPh[i] != n - 1) wrongPh++;
      total++; if (timedOut) begin bad++; $display("FAIL b2b_timeout[%0d]: got stuck expected done", t); end
      total++; if (addrAd !== a || addrCbe !== c)
        begin bad++; $display("FAIL b2b_addr[%0d]: got %h/%b expected %h/%b", t, addrAd, addrCbe, a, c); end
      total++; if (mism !== 0) begin bad++; $display("FAIL b2b_data[%0d]: got %0d words %0d wrong expected %0d", t, obs_q.size(), mism, exp_q.size()); end
      total++; if ((c[0] ? nRd : nWr) !== 0) begin bad++; $display("FAIL b2b_direction[%0d]: got rd=%0d wr=%0d expected one kind", t, nRd, nWr); end
      total++; if (doneCyc - dataStart !== expDone) begin bad++; $display("FAIL b2b_done[%0d]: got %0d expected %0d", t, doneCyc - dataStart, expDone); end
      total++; if (frameHighPh.size() != expFrame || wrongPh != 0)
        begin bad++; $display("FAIL b2b_frame[%0d]: got %0d clocks (%0d misplaced) expected %0d", t, frameHighPh.size(), wrongPh, expFrame); end
      total++; if (abortCnt !== int'(ab)) begin bad++; $display("FAIL b2b_abort[%0d]: got %0d expected %0d", t, abortCnt, ab); end
      total++; if (irdyGap !== 0 || turnBad !== 0 || idleBad !== 0 || busyBad !== 0 || doneCnt !== 1)
        begin bad++; $display("FAIL b2b_protocol[%0d]: got gap=%0d turn=%0d idle=%0d busy=%0d done=%0d expected 0 0 0 0 1",
                              t, irdyGap, turnBad, idleBad, busyBad, doneCnt); end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.gnt = 1'b1;
    bus.devSelect = 1'b1;
    bus.trdy = 1'b1;
    bus.ad_in = '0;
    test_reset();
    test_single_write();
    test_burst_read();
    test_master_abort();
    test_gnt_wait();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
